ddr_frame_buffer_sequencer: RTL and testbench

//  Owns NUM_BUFFERS DDR frame buffers shared by a video writer (camera DMA), a display reader and the DDR frame blanker.

---
 rtl/ddr_frame_buffer_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ddr_frame_buffer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_frame_buffer_sequencer.sv
// Frame buffer ownership tracker: hands clean buffers to the writer and ready frames to the reader, recycling via the blanker.
// FRAME_SEQ_BLANK_EN selects blanking through the external blanker; otherwise freed buffers become clean the next cycle.
module ddr_frame_buffer_sequencer #(
  parameter int                           FRAME_ADDR_LENGTH = 8,
  parameter int                           NUM_BUFFERS       = 3,
  parameter logic [FRAME_ADDR_LENGTH-1:0] BASE_FRAME_ADDR   = 8'h78,
  parameter logic [FRAME_ADDR_LENGTH-1:0] FRAME_ADDR_STEP   = 8'h01
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable_i,
  input  logic                         wr_frame_end_i,
  output logic                         wr_valid_o,
  output logic [FRAME_ADDR_LENGTH-1:0] wr_frame_addr_o,
  input  logic                         rd_frame_start_i,
  output logic                         rd_valid_o,
  output logic [FRAME_ADDR_LENGTH-1:0] rd_frame_addr_o,
  output logic [FRAME_ADDR_LENGTH-1:0] blank_frame_addr_o,
  output logic                         blank_swap_o,
  input  logic                         blank_done_i,
  output logic [15:0]                  drop_count_o,
  output logic [15:0]                  repeat_count_o
);
  localparam int FAL = FRAME_ADDR_LENGTH;

  typedef enum logic [2:0] {
    FREE = 3'd0, BLANKING = 3'd1, CLEAN = 3'd2, WRITING = 3'd3, READY = 3'd4, DISPLAY = 3'd5
  } buf_state_t;

  logic [NUM_BUFFERS-1:0][2:0] st_q, st_d;
  logic                        wr_valid_d, rd_valid_d;
  logic [FAL-1:0]              wr_addr_d, rd_addr_d;
  logic [15:0]                 drop_d, repeat_d;
  logic                        ready_found, clean_found, disp_found;
  logic [1:0]                  ready_idx, clean_idx, disp_idx, wrt_idx;
  logic                        wr_end, rd_start;

  function automatic logic [FAL-1:0] buf_addr(input logic [1:0] idx);
    return BASE_FRAME_ADDR + FAL'(idx) * FRAME_ADDR_STEP;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef FRAME_SEQ_BLANK_EN
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_WAIT} bstate_t;
  bstate_t        bstate_q, bstate_d;
  logic [1:0]     blank_idx_q, blank_idx_d, free_idx;
  logic [FAL-1:0] blank_addr_d;
  logic           swap_d, free_found;
`else
  logic unused_blank_done;
  assign unused_blank_done  = blank_done_i;
  assign blank_frame_addr_o = BASE_FRAME_ADDR;
  assign blank_swap_o       = 1'b0;
`endif

  // Lowest-index search over the pre-cycle state only; same-cycle changes become visible next cycle.
  always_comb begin
    ready_found = 1'b0; ready_idx = '0;
    clean_found = 1'b0; clean_idx = '0;
    disp_found  = 1'b0; disp_idx  = '0;
    wrt_idx     = '0;
`ifdef FRAME_SEQ_BLANK_EN
    free_found  = 1'b0; free_idx  = '0;
`endif
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (st_q[i] == READY)   begin ready_found = 1'b1; ready_idx = 2'(i); end
      if (st_q[i] == CLEAN)   begin clean_found = 1'b1; clean_idx = 2'(i); end
      if (st_q[i] == DISPLAY) begin disp_found  = 1'b1; disp_idx  = 2'(i); end
      if (st_q[i] == WRITING) wrt_idx = 2'(i);
`ifdef FRAME_SEQ_BLANK_EN
      if (st_q[i] == FREE)    begin free_found  = 1'b1; free_idx  = 2'(i); end
`endif
    end
  end

  always_comb begin
    st_d       = st_q;
    wr_valid_d = wr_valid_o;
    wr_addr_d  = wr_frame_addr_o;
    rd_valid_d = rd_valid_o;
    rd_addr_d  = rd_frame_addr_o;
    drop_d     = drop_count_o;
    repeat_d   = repeat_count_o;
    wr_end     = enable_i & wr_frame_end_i;
    rd_start   = enable_i & rd_frame_start_i;

    if (rd_start) begin
      if (ready_found) begin
        st_d[ready_idx] = DISPLAY;
        if (disp_found) st_d[disp_idx] = FREE;
        rd_valid_d = 1'b1;
        rd_addr_d  = buf_addr(ready_idx);
      end else begin
        repeat_d = sat_inc(repeat_count_o);
      end
    end

    // A READY frame taken by the reader in this same cycle is not a drop.
    if (wr_end) begin
      if (wr_valid_o) begin
        st_d[wrt_idx] = READY;
        if (ready_found && !rd_start) begin
          st_d[ready_idx] = FREE;
          drop_d = sat_inc(drop_count_o);
        end
      end else begin
        drop_d = sat_inc(drop_count_o);
      end
    end

    if (!wr_valid_o || wr_end) begin
      if (clean_found) begin
        st_d[clean_idx] = WRITING;
        wr_valid_d = 1'b1;
        wr_addr_d  = buf_addr(clean_idx);
      end else begin
        wr_valid_d = 1'b0;
      end
    end

`ifdef FRAME_SEQ_BLANK_EN
    bstate_d     = bstate_q;
    blank_idx_d  = blank_idx_q;
    blank_addr_d = blank_frame_addr_o;
    swap_d       = blank_swap_o;
    case (bstate_q)
      B_IDLE: if (enable_i && free_found) begin
        st_d[free_idx] = BLANKING;
        blank_idx_d    = free_idx;
        blank_addr_d   = buf_addr(free_idx);
        bstate_d       = B_SETUP;
      end
      B_SETUP: begin
        swap_d   = ~blank_swap_o;
        bstate_d = B_WAIT;
      end
      B_WAIT: if (blank_done_i) begin
        st_d[blank_idx_q] = CLEAN;
        bstate_d          = B_IDLE;
      end
      default: bstate_d = B_IDLE;
    endcase
`else
    for (int i = 0; i < NUM_BUFFERS; i++)
      if (enable_i && st_q[i] == FREE) st_d[i] = CLEAN;
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q            <= '0;
      wr_valid_o      <= 1'b0;
      wr_frame_addr_o <= BASE_FRAME_ADDR;
      rd_valid_o      <= 1'b0;
      rd_frame_addr_o <= BASE_FRAME_ADDR;
      drop_count_o    <= '0;
      repeat_count_o  <= '0;
    end else begin
      st_q            <= st_d;
      wr_valid_o      <= wr_valid_d;
      wr_frame_addr_o <= wr_addr_d;
      rd_valid_o      <= rd_valid_d;
      rd_frame_addr_o <= rd_addr_d;
      drop_count_o    <= drop_d;
      repeat_count_o  <= repeat_d;
    end
  end

`ifdef FRAME_SEQ_BLANK_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bstate_q           <= B_IDLE;
      blank_idx_q        <= '0;
      blank_frame_addr_o <= BASE_FRAME_ADDR;
      blank_swap_o       <= 1'b0;
    end else begin
      bstate_q           <= bstate_d;
      blank_idx_q        <= blank_idx_d;
      blank_frame_addr_o <= blank_addr_d;
      blank_swap_o       <= swap_d;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_frame_buffer_sequencer.sv
// Scoreboard bench for ddr_frame_buffer_sequencer with a blanker model answering 20 cycles after each toggle.
module tb_ddr_frame_buffer_sequencer;
  logic       aclk = 1'b0, areset = 1'b0, enable_i = 1'b1;
  logic       wr_frame_end_i = 1'b0, rd_frame_start_i = 1'b0;
  logic       done_model = 1'b0, done_man = 1'b0;
  logic       blank_done_i;
  logic       wr_valid_o, rd_valid_o, blank_swap_o;
  logic [7:0] wr_frame_addr_o, rd_frame_addr_o, blank_frame_addr_o;
  logic [15:0] drop_count_o, repeat_count_o;

  assign blank_done_i = done_model | done_man;
  always #5 aclk = ~aclk;

  ddr_frame_buffer_sequencer dut (
    .aclk(aclk), .areset(areset), .enable_i(enable_i),
    .wr_frame_end_i(wr_frame_end_i), .wr_valid_o(wr_valid_o), .wr_frame_addr_o(wr_frame_addr_o),
    .rd_frame_start_i(rd_frame_start_i), .rd_valid_o(rd_valid_o), .rd_frame_addr_o(rd_frame_addr_o),
    .blank_frame_addr_o(blank_frame_addr_o), .blank_swap_o(blank_swap_o), .blank_done_i(blank_done_i),
    .drop_count_o(drop_count_o), .repeat_count_o(repeat_count_o)
  );

  localparam int K_WRV = 0, K_WRA = 1, K_RDV = 2, K_RDA = 3, K_BA = 4, K_SW = 5, K_DROP = 6, K_REP = 7;

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tog_q[$];
  int         checks = 0, errors = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      K_WRV:  return {15'd0, wr_valid_o};
      K_WRA:  return {8'd0, wr_frame_addr_o};
      K_RDV:  return {15'd0, rd_valid_o};
      K_RDA:  return {8'd0, rd_frame_addr_o};
      K_BA:   return {8'd0, blank_frame_addr_o};
      K_SW:   return {15'd0, blank_swap_o};
      K_DROP: return drop_count_o;
      default: return repeat_count_o;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [15:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.kind), e.val);
    end
  endtask

  task automatic pulse(input logic wr, input logic rd);
    @(negedge aclk);
    wr_frame_end_i = wr; rd_frame_start_i = rd;
    @(negedge aclk);
    wr_frame_end_i = 1'b0; rd_frame_start_i = 1'b0;
  endtask

  task automatic wait_wr_valid(input string tag);
    int n = 0;
    while (wr_valid_o !== 1'b1 && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check_val(tag, {15'd0, wr_valid_o}, 16'd1);
  endtask

  task automatic expect_reset_values(input string tag);
    expect_val({tag, "_wrv"}, K_WRV, 16'd0);
    expect_val({tag, "_rdv"}, K_RDV, 16'd0);
    expect_val({tag, "_wra"}, K_WRA, 16'h78);
    expect_val({tag, "_rda"}, K_RDA, 16'h78);
    expect_val({tag, "_ba"},  K_BA,  16'h78);
    expect_val({tag, "_sw"},  K_SW,  16'd0);
    expect_val({tag, "_drop"}, K_DROP, 16'd0);
    expect_val({tag, "_rep"}, K_REP, 16'd0);
  endtask

  // Blanker model: records the address at each swap toggle and returns done 20 cycles later.
  initial begin
    logic last_swap;
    int   cnt;
    last_swap = 1'b0; cnt = 0;
    forever begin
      @(negedge aclk);
      done_model = 1'b0;
      if (areset) begin
        last_swap = 1'b0; cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) done_model = 1'b1;
        end
        if (blank_swap_o !== last_swap) begin
          last_swap = blank_swap_o;
          tog_q.push_back(blank_frame_addr_o);
          cnt = 20;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 areset = 1'b1;
    repeat (3) @(negedge aclk);
    expect_reset_values("rst");
    drain();
    areset = 1'b0;

    // T1: first buffer handed to the writer once cleaned
    wait_wr_valid("t1_wrv");
    expect_val("t1_wra", K_WRA, 16'h78);
    drain();
    repeat (120) @(negedge aclk);
`ifdef FRAME_SEQ_BLANK_EN
    check_val("t1_ntog", 16'(tog_q.size()), 16'd3);
    for (int i = 0; i < 3 && tog_q.size() > 0; i++)
      check_val("t1_tog", {8'd0, tog_q.pop_front()}, 16'(8'h78 + i));
`endif

    // T2: frame written then displayed
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    expect_val("t2_rdv", K_RDV, 16'd1);
    expect_val("t2_rda", K_RDA, 16'h78);
    expect_val("t2_wrv", K_WRV, 16'd1);
    expect_val("t2_wra", K_WRA, 16'h79);
    expect_val("t2_drop", K_DROP, 16'd0);
    drain();

    // T4: vsync without a new frame repeats
    pulse(1'b0, 1'b1);
    expect_val("t4_rda", K_RDA, 16'h78);
    expect_val("t4_rep", K_REP, 16'd1);
    drain();

    // T3: two frames back to back, older READY dropped and recycled
    pulse(1'b1, 1'b0);
    expect_val("t3_wra1", K_WRA, 16'h7A);
    drain();
    pulse(1'b1, 1'b0);
    expect_val("t3_drop", K_DROP, 16'd1);
    expect_val("t3_wrv0", K_WRV, 16'd0);
    drain();
    wait_wr_valid("t3_wrv1");
    expect_val("t3_wra2", K_WRA, 16'h79);
    drain();
`ifdef FRAME_SEQ_BLANK_EN
    check_val("t3_tog", (tog_q.size() > 0) ? {8'd0, tog_q.pop_front()} : 16'hFFFF, 16'h79);
`endif

    // T5: write end and vsync together; reader takes the older READY
    pulse(1'b1, 1'b1);
    expect_val("t5_rda", K_RDA, 16'h7A);
    expect_val("t5_rdv", K_RDV, 16'd1);
    expect_val("t5_drop", K_DROP, 16'd1);
    expect_val("t5_wrv", K_WRV, 16'd0);
    drain();
    // frame end while the writer holds no buffer counts as a drop
    wr_frame_end_i = 1'b1;
    @(negedge aclk);
    wr_frame_end_i = 1'b0;
    expect_val("t5_nobuf_drop", K_DROP, 16'd2);
    drain();
    wait_wr_valid("t5_wrv1");
    expect_val("t5_wra", K_WRA, 16'h78);
    drain();
    pulse(1'b0, 1'b1);
    expect_val("t5_rda2", K_RDA, 16'h79);
    expect_val("t5_rep", K_REP, 16'd1);
    drain();

    // Disabled: frame events ignored and not counted
    enable_i = 1'b0;
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    expect_val("dis_rep", K_REP, 16'd1);
    expect_val("dis_drop", K_DROP, 16'd2);
    expect_val("dis_rda", K_RDA, 16'h79);
    expect_val("dis_wra", K_WRA, 16'h78);
    drain();
    enable_i = 1'b1;

    // T6: reset mid-operation, late done ignored, blanking restarts from buffer 0
    repeat (4) @(negedge aclk);
    areset = 1'b1;
    repeat (25) @(negedge aclk);
    expect_reset_values("t6");
    drain();
    tog_q.delete();
    areset = 1'b0;
    done_man = 1'b1;
    @(negedge aclk);
    done_man = 1'b0;
    wait_wr_valid("t6_wrv");
    expect_val("t6_wra", K_WRA, 16'h78);
    expect_val("t6_drop", K_DROP, 16'd0);
    drain();
`ifdef FRAME_SEQ_BLANK_EN
    check_val("t6_tog", (tog_q.size() > 0) ? {8'd0, tog_q.pop_front()} : 16'hFFFF, 16'h78);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
